// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - shared state type and word-field positions for the TM1638 transmitter
package tm1638_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STB_SETUP,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_HOLD,
        ST_STB_END,
        ST_GAP
    } tm1638_tx_state_t;

    localparam int SOF_BIT  = 17;
    localparam int EOF_BIT  = 16;
    localparam int BYTE_MSB = 7;

    // States whose duration is one TM1638 half-period.
    function automatic logic is_half_period(tm1638_tx_state_t s);
        return s inside {ST_STB_SETUP, ST_BIT_LOW, ST_BIT_HIGH, ST_STB_END};
    endfunction

endpackage

// File: rtl/tm1638_clk_div.sv
// rtl/tm1638_clk_div.sv - loadable down-counter giving a one-cycle tick N cycles after load
module tm1638_clk_div #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] count,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = count;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick in the last cycle of the loaded interval so the owner leaves on the next edge.
    assign tick = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/tm1638_fifo_tx.sv
// rtl/tm1638_fifo_tx.sv - pops command words from a FIFO and shifts them onto the TM1638 STB/CLK/DIO bus
module tm1638_fifo_tx
    import tm1638_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int CLK_DIV    = 4,
    parameter int STB_GAP    = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Empty,
    input  logic [DATA_WIDTH-1:0] i_Data,
    output logic                  o_Read,
    output logic                  o_Busy,
    output logic                  o_TM_STB,
    output logic                  o_TM_CLK,
    output logic                  o_TM_DIO
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(STB_GAP + 1);

    tm1638_tx_state_t state_q, state_d;
    logic [BYTE_MSB:0] shift_q, shift_d;
    logic              eof_q, eof_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_MSB:0] pend_byte_q, pend_byte_d;
    logic              pend_eof_q, pend_eof_d;
    logic              pend_vld_q, pend_vld_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              stb_q, stb_d;
    logic              clk_q, clk_d;
    logic              dio_q, dio_d;

    logic div_load, div_tick;
    logic gap_load, gap_tick;
    logic data_unused;

    assign data_unused = ^i_Data[EOF_BIT-1:BYTE_MSB+1];

    tm1638_clk_div #(.WIDTH(DIV_W)) u_half_div (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .load  (div_load),
        .count (DIV_W'(CLK_DIV)),
        .tick  (div_tick)
    );

    tm1638_clk_div #(.WIDTH(GAP_W)) u_gap_div (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .load  (gap_load),
        .count (GAP_W'(STB_GAP)),
        .tick  (gap_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        eof_d       = eof_q;
        bit_cnt_d   = bit_cnt_q;
        pend_byte_d = pend_byte_q;
        pend_eof_d  = pend_eof_q;
        pend_vld_d  = pend_vld_q;
        read_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!i_Empty) begin
                    read_d  = 1'b1;
                    shift_d = i_Data[BYTE_MSB:0];
                    eof_d   = i_Data[EOF_BIT];
                    state_d = ST_STB_SETUP;
                end
            end
            ST_STB_SETUP: begin
                if (div_tick) state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW: begin
                if (div_tick) state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (div_tick) begin
                    shift_d   = {1'b0, shift_q[BYTE_MSB:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = eof_q ? ST_STB_END : ST_HOLD;
                    end else begin
                        state_d = ST_BIT_LOW;
                    end
                end
            end
            ST_HOLD: begin
                if (!i_Empty) begin
                    read_d = 1'b1;
                    // A new SOF closes the open frame first; the word waits out the gap.
                    if (i_Data[SOF_BIT]) begin
                        pend_byte_d = i_Data[BYTE_MSB:0];
                        pend_eof_d  = i_Data[EOF_BIT];
                        pend_vld_d  = 1'b1;
                        state_d     = ST_STB_END;
                    end else begin
                        shift_d = i_Data[BYTE_MSB:0];
                        eof_d   = i_Data[EOF_BIT];
                        state_d = ST_BIT_LOW;
                    end
                end
            end
            ST_STB_END: begin
                if (div_tick) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_tick) begin
                    if (pend_vld_q) begin
                        shift_d    = pend_byte_q;
                        eof_d      = pend_eof_q;
                        pend_vld_d = 1'b0;
                        state_d    = ST_STB_SETUP;
                    end else if (!i_Empty) begin
                        // Popping on the gap's last edge keeps STB high for exactly STB_GAP cycles.
                        read_d  = 1'b1;
                        shift_d = i_Data[BYTE_MSB:0];
                        eof_d   = i_Data[EOF_BIT];
                        state_d = ST_STB_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_load = (state_d != state_q) && is_half_period(state_d);
        gap_load = (state_d == ST_GAP) && (state_q != ST_GAP);
        stb_d    = (state_d == ST_IDLE) || (state_d == ST_GAP);
        clk_d    = (state_d != ST_BIT_LOW);
        dio_d    = (state_d == ST_BIT_LOW) ? shift_d[0] : dio_q;
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            eof_q       <= 1'b0;
            bit_cnt_q   <= 3'd0;
            pend_byte_q <= '0;
            pend_eof_q  <= 1'b0;
            pend_vld_q  <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            stb_q       <= 1'b1;
            clk_q       <= 1'b1;
            dio_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            eof_q       <= eof_d;
            bit_cnt_q   <= bit_cnt_d;
            pend_byte_q <= pend_byte_d;
            pend_eof_q  <= pend_eof_d;
            pend_vld_q  <= pend_vld_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            stb_q       <= stb_d;
            clk_q       <= clk_d;
            dio_q       <= dio_d;
        end
    end

    assign o_Read   = read_q;
    assign o_Busy   = busy_q;
    assign o_TM_STB = stb_q;
    assign o_TM_CLK = clk_q;
    assign o_TM_DIO = dio_q;

endmodule

// File: tb/tb_tm1638_fifo_tx.sv
// tb/tb_tm1638_fifo_tx.sv - scoreboard bench: FIFO model feeds the transmitter, bus monitor decodes frames
module tb_tm1638_fifo_tx;

    localparam int CLK_DIV = 2;
    localparam int STB_GAP = 4;
    localparam int DW      = 18;

    logic          i_Clk   = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Empty = 1'b1;
    logic [DW-1:0] i_Data  = '0;
    logic          o_Read, o_Busy, o_TM_STB, o_TM_CLK, o_TM_DIO;

    int checks = 0;
    int errors = 0;

    always #5 i_Clk = ~i_Clk;

    tm1638_fifo_tx #(.DATA_WIDTH(DW), .CLK_DIV(CLK_DIV), .STB_GAP(STB_GAP)) dut (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Empty  (i_Empty),
        .i_Data   (i_Data),
        .o_Read   (o_Read),
        .o_Busy   (o_Busy),
        .o_TM_STB (o_TM_STB),
        .o_TM_CLK (o_TM_CLK),
        .o_TM_DIO (o_TM_DIO)
    );

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // FIFO contents and the reference model of frames (byte stream plus frame lengths).
    logic [DW-1:0] fifo_q[$];
    logic [7:0]    exp_bytes[$];
    int            exp_frames[$];
    bit            model_open = 0;
    int            model_len = 0;
    int            pushed_words = 0;
    int            read_count = 0;

    task automatic push_word(bit sof, bit eof, logic [7:0] b);
        logic [DW-1:0] w;
        w        = '0;
        w[17]    = sof;
        w[16]    = eof;
        w[15:8]  = 8'($urandom);
        w[7:0]   = b;
        fifo_q.push_back(w);
        pushed_words++;
        if (model_open && sof) begin
            exp_frames.push_back(model_len);
            model_open = 0;
        end
        if (!model_open) begin
            model_open = 1;
            model_len  = 0;
        end
        exp_bytes.push_back(b);
        model_len++;
        if (eof) begin
            exp_frames.push_back(model_len);
            model_open = 0;
        end
    endtask

    always @(negedge i_Clk) begin
        if (o_Read === 1'b1) begin
            read_count++;
            if (fifo_q.size() == 0) check("read_on_empty", 1, 0);
            else void'(fifo_q.pop_front());
        end
        i_Empty = (fifo_q.size() == 0);
        i_Data  = i_Empty ? '0 : fifo_q[0];
    end

    // Bus monitor: decodes bytes on CLK rises and checks bus timing rules.
    logic       prev_stb = 1'b1, prev_clk = 1'b1, prev_dio = 1'b1;
    logic [7:0] acc = '0;
    int cyc = 0, stb_fall_cyc = 0, stb_rise_cyc = -1000, low_start = 0, last_rise = 0;
    int bitn = 0, frame_bytes = 0, frame_rises = 0;
    int last_gap = 0, last_tail = 0, last_frame_rises = 0;
    bit first_fall = 0;

    always @(negedge i_Clk) begin
        cyc++;
        if (!i_Rst_n) begin
            prev_stb = 1'b1; prev_clk = 1'b1; prev_dio = 1'b1;
            bitn = 0; frame_bytes = 0; frame_rises = 0; first_fall = 0;
            stb_rise_cyc = -1000;
        end else begin
            if (o_TM_STB !== prev_stb && (o_TM_CLK !== 1'b1 || prev_clk !== 1'b1))
                check("stb_moved_with_clk_low", 1, 0);
            if (o_TM_DIO !== prev_dio && !(prev_clk === 1'b1 && o_TM_CLK === 1'b0))
                check("dio_moved_off_clk_fall", 1, 0);
            if (prev_stb === 1'b1 && o_TM_STB === 1'b0) begin
                stb_fall_cyc = cyc;
                first_fall   = 1;
                last_gap     = cyc - stb_rise_cyc;
                check("min_stb_gap", last_gap >= STB_GAP, 1);
            end
            if (prev_clk === 1'b1 && o_TM_CLK === 1'b0) begin
                if (first_fall) check("stb_to_first_clk_fall", cyc - stb_fall_cyc, CLK_DIV);
                first_fall = 0;
                low_start  = cyc;
            end
            if (prev_clk === 1'b0 && o_TM_CLK === 1'b1 && o_TM_STB === 1'b0) begin
                check("clk_low_time", cyc - low_start, CLK_DIV);
                acc = {o_TM_DIO, acc[7:1]};
                bitn++;
                frame_rises++;
                last_rise = cyc;
                if (bitn == 8) begin
                    bitn = 0;
                    frame_bytes++;
                    if (exp_bytes.size() == 0) check("unexpected_byte", acc, -1);
                    else check("byte", acc, exp_bytes.pop_front());
                end
            end
            if (prev_stb === 1'b0 && o_TM_STB === 1'b1) begin
                stb_rise_cyc     = cyc;
                last_tail        = cyc - last_rise;
                last_frame_rises = frame_rises;
                check("tail_min", last_tail >= 2 * CLK_DIV, 1);
                check("frame_bit_align", bitn, 0);
                if (exp_frames.size() == 0) check("unexpected_frame", frame_bytes, -1);
                else check("frame_len", frame_bytes, exp_frames.pop_front());
                frame_bytes = 0;
                frame_rises = 0;
            end
            prev_stb = o_TM_STB;
            prev_clk = o_TM_CLK;
            prev_dio = o_TM_DIO;
        end
    end

    task automatic wait_stb(logic lvl, string name);
        int n;
        n = 0;
        while (o_TM_STB !== lvl && n < 2000) begin
            @(negedge i_Clk);
            n++;
        end
        check({name, "_stb_timeout"}, n < 2000, 1);
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || i_Empty !== 1'b1 || o_Busy !== 1'b0) && n < 5000) begin
            @(negedge i_Clk);
            n++;
        end
        check({name, "_drain_timeout"}, n < 5000, 1);
        repeat (3) @(negedge i_Clk);
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_frames_left"}, exp_frames.size(), 0);
        check({name, "_reads"}, read_count, pushed_words);
    endtask

    initial begin
        int reads0, busy_low, n, nb;
        bit sof, eof;
        logic dio_ref;
        bit stb_bad, clk_bad, dio_bad;

        repeat (3) @(negedge i_Clk);
        check("rst_stb", o_TM_STB, 1);
        check("rst_clk", o_TM_CLK, 1);
        check("rst_dio", o_TM_DIO, 1);
        check("rst_read", o_Read, 0);
        check("rst_busy", o_Busy, 0);
        i_Rst_n = 1'b1;
        @(negedge i_Clk);

        // Single framed byte 0x40.
        push_word(1, 1, 8'h40);
        drain("t1");
        check("t1_tail", last_tail, 2 * CLK_DIV);
        check("t1_rises", last_frame_rises, 8);

        // Three bytes in one frame.
        push_word(1, 0, 8'hC0);
        push_word(0, 0, 8'h3F);
        push_word(0, 1, 8'h06);
        drain("t2");
        check("t2_rises", last_frame_rises, 24);

        // Frame held open while the FIFO runs dry.
        push_word(1, 0, 8'hC0);
        n = 0;
        while (frame_bytes < 1 && n < 2000) begin
            @(negedge i_Clk);
            n++;
        end
        check("t3_first_byte_timeout", n < 2000, 1);
        repeat (4) @(negedge i_Clk);
        dio_ref = o_TM_DIO;
        stb_bad = 0; clk_bad = 0; dio_bad = 0;
        repeat (50) begin
            if (o_TM_STB !== 1'b0) stb_bad = 1;
            if (o_TM_CLK !== 1'b1) clk_bad = 1;
            if (o_TM_DIO !== dio_ref) dio_bad = 1;
            @(negedge i_Clk);
        end
        check("t3_stb_held_low", stb_bad, 0);
        check("t3_clk_held_high", clk_bad, 0);
        check("t3_dio_stable", dio_bad, 0);
        check("t3_busy_in_hold", o_Busy, 1);
        push_word(0, 1, 8'h5B);
        drain("t3");

        // SOF inside an open frame splits it with an exact gap.
        reads0 = read_count;
        push_word(1, 0, 8'h44);
        push_word(1, 1, 8'hC2);
        drain("t4");
        check("t4_gap", last_gap, STB_GAP);
        check("t4_reads", read_count - reads0, 2);

        // Async reset in the middle of bit 3 of 0xFF.
        push_word(1, 1, 8'hFF);
        wait_stb(1'b0, "t5");
        repeat (2 + 3 * 2 * CLK_DIV) @(negedge i_Clk);
        #2;
        i_Rst_n = 1'b0;
        #1;
        check("t5_stb", o_TM_STB, 1);
        check("t5_clk", o_TM_CLK, 1);
        check("t5_dio", o_TM_DIO, 1);
        check("t5_read", o_Read, 0);
        check("t5_busy", o_Busy, 0);
        exp_bytes.delete();
        exp_frames.delete();
        model_open = 0;
        repeat (2) @(negedge i_Clk);
        i_Rst_n = 1'b1;
        @(negedge i_Clk);
        check("t5_busy_after_release", o_Busy, 0);
        push_word(1, 1, 8'hA5);
        drain("t5");

        // Two queued single-byte frames: exact gap, busy held.
        push_word(1, 1, 8'h12);
        push_word(1, 1, 8'h34);
        wait_stb(1'b0, "t6a");
        wait_stb(1'b1, "t6b");
        busy_low = 0;
        n = 0;
        while (o_TM_STB === 1'b1 && n < 50) begin
            if (o_Busy !== 1'b1) busy_low++;
            @(negedge i_Clk);
            n++;
        end
        check("t6_busy_in_gap", busy_low, 0);
        drain("t6");
        check("t6_gap", last_gap, STB_GAP);

        // Randomized frames with random FIFO starvation.
        for (int b = 0; b < 10; b++) begin
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) begin
                sof = (k == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
                eof = (k == nb - 1) ? 1'b1 : ($urandom_range(0, 4) == 0);
                push_word(sof, eof, 8'($urandom));
                repeat ($urandom_range(0, 30)) @(negedge i_Clk);
            end
            drain("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
